// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } ss_state_t;

    // Bit-counter width: enough to count WIDTH steps, never narrower than one bit.
    function automatic int cnt_width(input int width);
        if ($clog2(width) < 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with the outgoing borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell walks a - b LSB first,
// operands latched on start, result published atomically with a one-cycle done pulse.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    ss_state_t        r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_work_next;

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // New difference bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    assign w_work_next = (r_work >> 1'b1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    // Handshake FSM, operand shift registers, borrow flop and published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_work  <= '0;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a    <= r_a >> 1'b1;
                    r_b    <= r_b >> 1'b1;
                    r_work <= w_work_next;
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + CW'(1'b1);
                    if (w_last) begin
                        r_diff   <= w_work_next;
                        r_borrow <= w_bout;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule
